lcd_8080_bus_master: RTL and testbench

LCD_8080_BUS_MASTER -- requirements
Module: lcd_8080_bus_master

---
 rtl/hx8352_pkg.sv | 26 ++
 rtl/lcd_8080_bus_master_if.sv | 36 +++
 rtl/lcd_phase_timer.sv | 35 +++
 rtl/lcd_8080_bus_master.sv | 166 ++++++++++++++++
 tb/tb_lcd_8080_bus_master.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hx8352_pkg.sv
// Shared constants for the 8080-style LCD bus master: phase encoding,
// default panel timing and the phase-counter sizing helper.
package hx8352_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } lcd_state_e;

  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_SETUP_CYCLES  = 1;
  localparam int DEF_STROBE_CYCLES = 1;
  localparam int DEF_HOLD_CYCLES   = 1;

  // Counter holds (cycles - 1), so clog2 of the longest phase suffices.
  function automatic int phase_cnt_width(input int s, input int t, input int h);
    int m;
    m = s;
    if (t > m) m = t;
    if (h > m) m = h;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/lcd_8080_bus_master_if.sv
// Request/response handshake plus split-tristate 8080 panel bus.
// master = bus-master side, slave = requester/panel side.
interface lcd_8080_bus_master_if #(
  parameter int DATA_WIDTH = hx8352_pkg::DEF_DATA_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_rs;
  logic                  req_rnw;
  logic [DATA_WIDTH-1:0] req_data;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;

  logic                  lcd_cs_n;
  logic                  lcd_rs;
  logic                  lcd_wr_n;
  logic                  lcd_rd_n;
  logic [DATA_WIDTH-1:0] lcd_data_out;
  logic                  lcd_data_oe;
  logic [DATA_WIDTH-1:0] lcd_data_in;

  modport master (
    input  req_valid, req_rs, req_rnw, req_data, lcd_data_in,
    output req_ready, rsp_valid, rsp_data,
    output lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_data_out, lcd_data_oe
  );

  modport slave (
    output req_valid, req_rs, req_rnw, req_data, lcd_data_in,
    input  req_ready, rsp_valid, rsp_data,
    input  lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_data_out, lcd_data_oe
  );

endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter for phase timing; done is high while the count is zero.
// Load has priority; the count saturates at zero instead of wrapping.
module lcd_phase_timer #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_8080_bus_master.sv
// 8080-style LCD bus master: one command/data read or write per request.
// Fully registered outputs; req_ready only in IDLE, period SETUP+STROBE+HOLD+1 cycles.
module lcd_8080_bus_master
  import hx8352_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  lcd_8080_bus_master_if.master bus
);

  localparam int CNT_W = phase_cnt_width(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

  generate
    if (SETUP_CYCLES < 1 || STROBE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_cycles
      $error("lcd_8080_bus_master: SETUP/STROBE/HOLD_CYCLES must all be >= 1");
    end
    if (DATA_WIDTH != 8 && DATA_WIDTH != 16) begin : g_bad_width
      $error("lcd_8080_bus_master: DATA_WIDTH must be 8 or 16");
    end
  endgenerate

  lcd_state_e            state_q, state_d;
  logic                  rs_q, rs_d;
  logic                  rnw_q, rnw_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  cs_n_q, cs_n_d;
  logic                  lcd_rs_q, lcd_rs_d;
  logic                  wr_n_q, wr_n_d;
  logic                  rd_n_q, rd_n_d;
  logic                  oe_q, oe_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  logic                  tmr_load;
  logic [CNT_W-1:0]      tmr_val;
  logic                  tmr_done;
  logic                  accept;
  logic                  active;

  lcd_phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // req_ready_q is low on the first IDLE cycle after reset, so that cycle never accepts.
  assign accept = (state_q == ST_IDLE) && req_ready_q && bus.req_valid;

  always_comb begin
    state_d     = state_q;
    rs_d        = rs_q;
    rnw_d       = rnw_q;
    data_d      = data_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LOAD;
          rs_d     = bus.req_rs;
          rnw_d    = bus.req_rnw;
          data_d   = bus.req_data;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          state_d  = ST_STROBE;
          tmr_load = 1'b1;
          tmr_val  = STROBE_LOAD;
        end
      end
      ST_STROBE: begin
        if (tmr_done) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LOAD;
          if (rnw_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = bus.lcd_data_in;
          end
        end
      end
      ST_HOLD: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Pins are decoded from the next state so they line up with it cycle for cycle.
    active      = (state_d != ST_IDLE);
    req_ready_d = !active;
    cs_n_d      = !active;
    lcd_rs_d    = active ? rs_d : 1'b1;
    wr_n_d      = !((state_d == ST_STROBE) && !rnw_d);
    rd_n_d      = !((state_d == ST_STROBE) && rnw_d);
    oe_d        = active && !rnw_d;
    dout_d      = oe_d ? data_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rs_q        <= 1'b1;
      rnw_q       <= 1'b0;
      data_q      <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cs_n_q      <= 1'b1;
      lcd_rs_q    <= 1'b1;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      oe_q        <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      rs_q        <= rs_d;
      rnw_q       <= rnw_d;
      data_q      <= data_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cs_n_q      <= cs_n_d;
      lcd_rs_q    <= lcd_rs_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
      oe_q        <= oe_d;
      dout_q      <= dout_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.lcd_cs_n     = cs_n_q;
  assign bus.lcd_rs       = lcd_rs_q;
  assign bus.lcd_wr_n     = wr_n_q;
  assign bus.lcd_rd_n     = rd_n_q;
  assign bus.lcd_data_oe  = oe_q;
  assign bus.lcd_data_out = dout_q;

endmodule

// File: tb/tb_lcd_8080_bus_master.sv
// Bench for lcd_8080_bus_master: three instances (defaults, 2/3/1 timing, 8-bit)
// checked every cycle against an elapsed-time model plus literal per-cycle expectations.
module tb_lcd_8080_bus_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  localparam int P_S [3] = '{1, 2, 1};
  localparam int P_T [3] = '{1, 3, 1};
  localparam int P_H [3] = '{1, 1, 1};
  localparam int P_W [3] = '{16, 16, 8};

  logic [2:0]  vld_t = '0;
  logic [2:0]  rs_t  = '0;
  logic [2:0]  rnw_t = '0;
  logic [15:0] dat_t [3];
  logic [15:0] din_t [3];

  lcd_8080_bus_master_if #(.DATA_WIDTH(16)) if0 ();
  lcd_8080_bus_master_if #(.DATA_WIDTH(16)) if1 ();
  lcd_8080_bus_master_if #(.DATA_WIDTH(8))  if2 ();

  lcd_8080_bus_master #(.DATA_WIDTH(16), .SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1))
    dut0 (.clk(clk), .rst(rst), .bus(if0.master));
  lcd_8080_bus_master #(.DATA_WIDTH(16), .SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1.master));
  lcd_8080_bus_master #(.DATA_WIDTH(8), .SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1))
    dut2 (.clk(clk), .rst(rst), .bus(if2.master));

  assign if0.req_valid   = vld_t[0];
  assign if0.req_rs      = rs_t[0];
  assign if0.req_rnw     = rnw_t[0];
  assign if0.req_data    = dat_t[0];
  assign if0.lcd_data_in = din_t[0];
  assign if1.req_valid   = vld_t[1];
  assign if1.req_rs      = rs_t[1];
  assign if1.req_rnw     = rnw_t[1];
  assign if1.req_data    = dat_t[1];
  assign if1.lcd_data_in = din_t[1];
  assign if2.req_valid   = vld_t[2];
  assign if2.req_rs      = rs_t[2];
  assign if2.req_rnw     = rnw_t[2];
  assign if2.req_data    = dat_t[2][7:0];
  assign if2.lcd_data_in = din_t[2][7:0];

  typedef struct packed {
    logic        rdy;
    logic        rspv;
    logic [15:0] rspd;
    logic        cs_n;
    logic        rs;
    logic        wr_n;
    logic        rd_n;
    logic        oe;
    logic [15:0] dout;
  } obs_t;

  obs_t obs0, obs1, obs2;
  assign obs0 = {if0.req_ready, if0.rsp_valid, if0.rsp_data, if0.lcd_cs_n, if0.lcd_rs,
                 if0.lcd_wr_n, if0.lcd_rd_n, if0.lcd_data_oe, if0.lcd_data_out};
  assign obs1 = {if1.req_ready, if1.rsp_valid, if1.rsp_data, if1.lcd_cs_n, if1.lcd_rs,
                 if1.lcd_wr_n, if1.lcd_rd_n, if1.lcd_data_oe, if1.lcd_data_out};
  assign obs2 = {if2.req_ready, if2.rsp_valid, 8'h00, if2.rsp_data, if2.lcd_cs_n, if2.lcd_rs,
                 if2.lcd_wr_n, if2.lcd_rd_n, if2.lcd_data_oe, 8'h00, if2.lcd_data_out};

  function automatic obs_t obs_of(input int i);
    case (i)
      0:       return obs0;
      1:       return obs1;
      default: return obs2;
    endcase
  endfunction

  // Model: m_t counts cycles since accept (0 = idle); pins follow from m_t alone.
  int          m_t    [3];
  logic        m_rdy  [3];
  logic        m_rs   [3];
  logic        m_rnw  [3];
  logic        m_rspv [3];
  logic [15:0] m_dat  [3];
  logic [15:0] m_rspd [3];

  function automatic logic [15:0] wmask(input int i);
    return (P_W[i] == 8) ? 16'h00FF : 16'hFFFF;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_t[i]    <= 0;
        m_rdy[i]  <= 1'b0;
        m_rspv[i] <= 1'b0;
        m_rspd[i] <= 16'h0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_rspv[i] <= 1'b0;
        if (m_t[i] != 0) begin
          if (m_rnw[i] && m_t[i] == P_S[i] + P_T[i]) begin
            m_rspd[i] <= din_t[i] & wmask(i);
            m_rspv[i] <= 1'b1;
          end
          if (m_t[i] == P_S[i] + P_T[i] + P_H[i]) begin
            m_t[i]   <= 0;
            m_rdy[i] <= 1'b1;
          end else begin
            m_t[i]   <= m_t[i] + 1;
            m_rdy[i] <= 1'b0;
          end
        end else if (m_rdy[i] && vld_t[i]) begin
          m_t[i]   <= 1;
          m_rdy[i] <= 1'b0;
          m_rs[i]  <= rs_t[i];
          m_rnw[i] <= rnw_t[i];
          m_dat[i] <= dat_t[i] & wmask(i);
        end else begin
          m_rdy[i] <= 1'b1;
        end
      end
    end
  end

  function automatic obs_t model_of(input int i);
    obs_t o;
    logic act, stb;
    act    = (m_t[i] != 0);
    stb    = act && (m_t[i] > P_S[i]) && (m_t[i] <= P_S[i] + P_T[i]);
    o.rdy  = m_rdy[i];
    o.rspv = m_rspv[i];
    o.rspd = m_rspd[i];
    o.cs_n = !act;
    o.rs   = act ? m_rs[i] : 1'b1;
    o.wr_n = !(stb && !m_rnw[i]);
    o.rd_n = !(stb && m_rnw[i]);
    o.oe   = act && !m_rnw[i];
    o.dout = o.oe ? m_dat[i] : 16'h0;
    return o;
  endfunction

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dut%0d_outputs", i), 64'(obs_of(i)), 64'(model_of(i)));
    end
  end

  task automatic wait_ready(input int i);
    obs_t o;
    int k;
    k = 0;
    o = obs_of(i);
    while (o.rdy !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
      o = obs_of(i);
    end
    chk($sformatf("dut%0d_ready_wait", i), 64'(o.rdy), 64'(1));
  endtask

  // Returns at the negedge of cycle 1 after the accept edge.
  task automatic send(input int i, input logic rs, input logic rnw, input logic [15:0] d);
    wait_ready(i);
    vld_t[i] = 1'b1;
    rs_t[i]  = rs;
    rnw_t[i] = rnw;
    dat_t[i] = d;
    @(negedge clk);
    vld_t[i] = 1'b0;
  endtask

  task automatic lit_write(input int i, input logic [15:0] d);
    obs_t o;
    send(i, 1'b0, 1'b0, d);
    for (int c = 1; c <= 4; c++) begin
      o = obs_of(i);
      chk($sformatf("dut%0d_wr_c%0d_cs_n", i, c), 64'(o.cs_n), 64'(c == 4));
      chk($sformatf("dut%0d_wr_c%0d_wr_n", i, c), 64'(o.wr_n), 64'(c != 2));
      chk($sformatf("dut%0d_wr_c%0d_rd_n", i, c), 64'(o.rd_n), 64'(1));
      chk($sformatf("dut%0d_wr_c%0d_oe", i, c), 64'(o.oe), 64'(c != 4));
      chk($sformatf("dut%0d_wr_c%0d_rdy", i, c), 64'(o.rdy), 64'(c == 4));
      if (c == 2) begin
        chk($sformatf("dut%0d_wr_c2_rs", i), 64'(o.rs), 64'(0));
        chk($sformatf("dut%0d_wr_c2_dout", i), 64'(o.dout), 64'(d));
      end
      if (c < 4) @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    obs_t        o;
    int          pulses, acc_n;
    logic        prev_rdy, prev_wr;
    int          acc_cyc [$];
    logic [15:0] seen [$];

    for (int i = 0; i < 3; i++) begin
      dat_t[i] = 16'h0;
      din_t[i] = 16'h0;
    end

    // Reset values, then ready on the first edge after release.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      o = obs_of(i);
      chk($sformatf("dut%0d_rst_rdy", i), 64'(o.rdy), 64'(0));
      chk($sformatf("dut%0d_rst_pins", i), 64'({o.cs_n, o.rs, o.wr_n, o.rd_n, o.oe}), 64'(5'b11110));
    end
    #2 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      o = obs_of(i);
      chk($sformatf("dut%0d_rel_rdy", i), 64'(o.rdy), 64'(1));
    end

    // Default-timing write, and the same timing on the 8-bit instance.
    lit_write(0, 16'h0022);
    lit_write(2, 16'h005A);

    // 2/3/1 read.
    din_t[1] = 16'hA5C3;
    send(1, 1'b1, 1'b1, 16'h0000);
    for (int c = 1; c <= 7; c++) begin
      o = obs_of(1);
      chk($sformatf("rd_c%0d_rd_n", c), 64'(o.rd_n), 64'(!(c >= 3 && c <= 5)));
      chk($sformatf("rd_c%0d_wr_n", c), 64'(o.wr_n), 64'(1));
      chk($sformatf("rd_c%0d_oe", c), 64'(o.oe), 64'(0));
      chk($sformatf("rd_c%0d_cs_n", c), 64'(o.cs_n), 64'(c == 7));
      chk($sformatf("rd_c%0d_rspv", c), 64'(o.rspv), 64'(c == 6));
      if (c >= 6) chk($sformatf("rd_c%0d_rspd", c), 64'(o.rspd), 64'(16'hA5C3));
      if (c < 7) @(negedge clk);
    end
    din_t[1] = 16'h1111;

    // Back-to-back writes with req_valid held high.
    wait_ready(0);
    vld_t[0] = 1'b1;
    rs_t[0]  = 1'b1;
    rnw_t[0] = 1'b0;
    dat_t[0] = 16'h0001;
    pulses   = 0;
    acc_n    = 0;
    prev_wr  = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      o = obs_of(0);
      prev_rdy = o.rdy;
      @(negedge clk);
      if (prev_rdy && vld_t[0]) begin
        acc_cyc.push_back(c);
        acc_n++;
        if (acc_n < 3) dat_t[0] = 16'(acc_n + 1);
        else vld_t[0] = 1'b0;
      end
      o = obs_of(0);
      if (!o.wr_n && prev_wr) begin
        pulses++;
        seen.push_back(o.dout);
      end
      prev_wr = o.wr_n;
    end
    chk("b2b_pulses", 64'(pulses), 64'(3));
    chk("b2b_accepts", 64'(acc_cyc.size()), 64'(3));
    chk("b2b_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'(4));
    chk("b2b_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'(4));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b2b_data%0d", k), 64'(seen[k]), 64'(k + 1));
    end

    // Request data changes right after accept; the captured word must stay on the pins.
    send(0, 1'b1, 1'b0, 16'h1234);
    dat_t[0] = 16'hFFFF;
    for (int c = 1; c <= 3; c++) begin
      o = obs_of(0);
      chk($sformatf("hold_c%0d_dout", c), 64'(o.dout), 64'(16'h1234));
      @(negedge clk);
    end

    // Extra vectors checked by the model only.
    send(1, 1'b0, 1'b0, 16'hBEEF);
    din_t[0] = 16'h8001;
    send(0, 1'b0, 1'b1, 16'h0000);
    din_t[2] = 16'h773C;
    send(2, 1'b1, 1'b1, 16'h0000);
    repeat (8) @(negedge clk);

    // Reset in the middle of a read strobe.
    din_t[1] = 16'h0F0F;
    send(1, 1'b1, 1'b1, 16'h0000);
    repeat (3) @(negedge clk);
    o = obs_of(1);
    chk("abort_pre_rd_n", 64'(o.rd_n), 64'(0));
    #2 rst = 1'b1;
    #1;
    o = obs_of(1);
    chk("abort_now_pins", 64'({o.cs_n, o.rs, o.wr_n, o.rd_n, o.oe}), 64'(5'b11110));
    chk("abort_now_rdy", 64'(o.rdy), 64'(0));
    chk("abort_now_rspv", 64'(o.rspv), 64'(0));
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    o = obs_of(1);
    chk("abort_rel_rdy", 64'(o.rdy), 64'(1));
    chk("abort_rel_rspd", 64'(o.rspd), 64'(0));
    for (int c = 0; c < 6; c++) begin
      o = obs_of(1);
      chk($sformatf("abort_after%0d", c), 64'({o.rspv, o.rd_n, o.cs_n}), 64'(3'b011));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
